// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared definitions for the ULPI receive framer.
// Holds the RX CMD field layout, the RxEvent encodings, the framer state
// enum and the default maximum packet length.
package ulpi_pkg;

    // 1024 payload bytes + PID + CRC16
    localparam int DEFAULT_MAX_PKT_BYTES = 1027;

    // Width of the per-packet byte counter
    localparam int LEN_W = 11;

    // RX CMD field positions (each field is two bits wide)
    localparam int RXCMD_LS_LSB    = 0;
    localparam int RXCMD_VBUS_LSB  = 2;
    localparam int RXCMD_EVENT_LSB = 4;

    // RxEvent field encodings
    typedef enum logic [1:0] {
        RXEV_NONE       = 2'b00,
        RXEV_ACTIVE     = 2'b01,
        RXEV_DISCONNECT = 2'b10,
        RXEV_ERROR      = 2'b11
    } rx_event_t;

    // Framer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_PKT  = 2'd2
    } rx_state_t;

    // An RX CMD with one of these events closes the current packet
    function automatic logic is_eop_event(rx_event_t ev);
        return (ev == RXEV_NONE) || (ev == RXEV_DISCONNECT);
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_decode.sv
// ulpi_rxcmd_decode: purely combinational split of an RX CMD byte into
// line state, VBUS state and RxEvent. Bits [7:6] (ID / alt_int) are not
// needed by the framer and are therefore not brought in.
module ulpi_rxcmd_decode
    import ulpi_pkg::*;
(
    input  logic [5:0] rxcmd_i,
    output logic [1:0] linestate_o,
    output logic [1:0] vbus_o,
    output logic [1:0] rx_event_o
);

    assign linestate_o = rxcmd_i[RXCMD_LS_LSB    +: 2];
    assign vbus_o      = rxcmd_i[RXCMD_VBUS_LSB  +: 2];
    assign rx_event_o  = rxcmd_i[RXCMD_EVENT_LSB +: 2];

endmodule

// File: rtl/ulpi_rx_framer.sv
// ulpi_rx_framer: link-side ULPI receive stage.
// Registers the ULPI pins, drops turnaround cycles, separates RX CMD bytes
// from data bytes, frames data into packets through a one-byte holding
// register (so the final byte can carry last/err) and publishes the most
// recent line state and VBUS state. The link never drives the bus: data
// out is a constant NOOP and stp is held low.
// Optional build macro ULPI_RX_STATS_EN adds saturating packet and error
// counters on pkt_count_o / err_count_o.
module ulpi_rx_framer
    import ulpi_pkg::*;
#(
    parameter int MAX_PKT_BYTES = DEFAULT_MAX_PKT_BYTES
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_stp_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_last_o,
    output logic       rx_err_o,
    output logic       rx_active_o,
    output logic [1:0] linestate_o,
    output logic [1:0] vbus_o
`ifdef ULPI_RX_STATS_EN
    ,
    output logic [15:0] pkt_count_o,
    output logic [15:0] err_count_o
`endif
);

    localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_PKT_BYTES);

    // Registered pins
    logic            r_dir_q;
    logic            r_nxt_q;
    logic [7:0]      r_data_q;
    logic            r_dir_prev;

    // Decoded cycle type
    logic [1:0]      w_linestate;
    logic [1:0]      w_vbus;
    logic [1:0]      w_event_raw;
    rx_event_t       w_event;
    logic            w_turn;
    logic            w_bus;
    logic            w_dbyte;
    logic            w_rxcmd;
    logic            w_accept;
    logic            w_eop;
    logic            w_set_err;

    // FSM and status
    rx_state_t       r_state;
    logic            r_rx_active;
    logic [1:0]      r_linestate;
    logic [1:0]      r_vbus;

    // Framing
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic [LEN_W-1:0] r_len;
    logic            r_err_flag;
    logic            r_rx_valid;
    logic [7:0]      r_rx_data;
    logic            r_rx_last;
    logic            r_rx_err;

    ulpi_rxcmd_decode u_rxcmd_decode (
        .rxcmd_i     (r_data_q[5:0]),
        .linestate_o (w_linestate),
        .vbus_o      (w_vbus),
        .rx_event_o  (w_event_raw)
    );

    // Capture the pad signals every cycle; dir is also delayed once more to find turnarounds
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dir_q    <= 1'b0;
            r_nxt_q    <= 1'b0;
            r_data_q   <= 8'h00;
            r_dir_prev <= 1'b0;
        end else begin
            r_dir_q    <= ulpi_dir_i;
            r_nxt_q    <= ulpi_nxt_i;
            r_data_q   <= ulpi_data_i;
            r_dir_prev <= r_dir_q;
        end
    end

    // Classify the registered cycle and derive the framing events for the current state
    always_comb begin
        w_event   = rx_event_t'(w_event_raw);
        w_turn    = r_dir_q & ~r_dir_prev;
        w_bus     = r_dir_q & ~w_turn;
        w_dbyte   = w_bus & r_nxt_q;
        w_rxcmd   = w_bus & ~r_nxt_q;
        w_accept  = w_dbyte && (r_state != S_IDLE);
        w_eop     = (r_state == S_PKT) &&
                    (!r_dir_q || (w_rxcmd && is_eop_event(w_event)));
        w_set_err = w_rxcmd && (w_event == RXEV_ERROR) && (r_state != S_IDLE);
    end

    // Track bus ownership and packet activity; rx_active is registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_rx_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_turn) begin
                        if (r_nxt_q) begin
                            r_state     <= S_PKT;
                            r_rx_active <= 1'b1;
                        end else begin
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (!r_dir_q) begin
                        r_state <= S_IDLE;
                    end else if (w_dbyte ||
                                 (w_rxcmd && ((w_event == RXEV_ACTIVE) ||
                                              (w_event == RXEV_ERROR)))) begin
                        r_state     <= S_PKT;
                        r_rx_active <= 1'b1;
                    end
                end
                S_PKT: begin
                    if (w_eop) begin
                        r_state     <= r_dir_q ? S_BUS : S_IDLE;
                        r_rx_active <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    // Every RX CMD refreshes the published line and VBUS state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_linestate <= 2'b00;
            r_vbus      <= 2'b00;
        end else if (w_rxcmd) begin
            r_linestate <= w_linestate;
            r_vbus      <= w_vbus;
        end
    end

    // Hold one byte back so the final byte of a packet can be tagged when the packet ends
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_len       <= '0;
            r_err_flag  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_last   <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_rx_err   <= 1'b0;
            if (w_eop) begin
                if (r_hold_full) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_hold;
                    r_rx_last  <= 1'b1;
                    r_rx_err   <= r_err_flag;
                end
                r_hold_full <= 1'b0;
                r_len       <= '0;
                r_err_flag  <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (r_len < LP_MAX_LEN) begin
                        if (r_hold_full) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_hold;
                        end
                        r_hold      <= r_data_q;
                        r_hold_full <= 1'b1;
                        r_len       <= r_len + LEN_W'(1);
                    end else begin
                        r_err_flag <= 1'b1;
                    end
                end
                if (w_set_err) begin
                    r_err_flag <= 1'b1;
                end
            end
        end
    end

`ifdef ULPI_RX_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_err_count;

    // Count completed and errored packets from the published last strobes, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pkt_count <= 16'h0000;
            r_err_count <= 16'h0000;
        end else if (r_rx_valid && r_rx_last) begin
            if (r_pkt_count != 16'hFFFF) begin
                r_pkt_count <= r_pkt_count + 16'h0001;
            end
            if (r_rx_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'h0001;
            end
        end
    end

    assign pkt_count_o = r_pkt_count;
    assign err_count_o = r_err_count;
`endif

    assign ulpi_data_o = 8'h00;
    assign ulpi_stp_o  = 1'b0;
    assign rx_valid_o  = r_rx_valid;
    assign rx_data_o   = r_rx_data;
    assign rx_last_o   = r_rx_last;
    assign rx_err_o    = r_rx_err;
    assign rx_active_o = r_rx_active;
    assign linestate_o = r_linestate;
    assign vbus_o      = r_vbus;

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// tb_ulpi_rx_framer: self-checking bench for ulpi_rx_framer.
// Pin-level stimulus is generated as ULPI transactions; a packet-level model
// turns those transactions into the strobes, line state and activity the
// framer must produce, and a per-cycle compare process checks the DUT.
module tb_ulpi_rx_framer;

    localparam int MAX_BYTES = 1027;
    localparam int HIST      = 16384;

    logic       clk_i       = 1'b0;
    logic       rst_i       = 1'b1;
    logic [7:0] ulpi_data_i = 8'h00;
    logic       ulpi_dir_i  = 1'b0;
    logic       ulpi_nxt_i  = 1'b0;
    wire  [7:0] ulpi_data_o;
    wire        ulpi_stp_o;
    wire        rx_valid_o;
    wire  [7:0] rx_data_o;
    wire        rx_last_o;
    wire        rx_err_o;
    wire        rx_active_o;
    wire  [1:0] linestate_o;
    wire  [1:0] vbus_o;
`ifdef ULPI_RX_STATS_EN
    wire [15:0] pktCount;
    wire [15:0] errCount;
`endif

    ulpi_rx_framer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ulpi_data_i (ulpi_data_i),
        .ulpi_dir_i  (ulpi_dir_i),
        .ulpi_nxt_i  (ulpi_nxt_i),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_stp_o  (ulpi_stp_o),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_last_o   (rx_last_o),
        .rx_err_o    (rx_err_o),
        .rx_active_o (rx_active_o),
        .linestate_o (linestate_o),
        .vbus_o      (vbus_o)
`ifdef ULPI_RX_STATS_EN
        ,
        .pkt_count_o (pktCount),
        .err_count_o (errCount)
`endif
    );

    // Free-running clock, roughly 60 MHz
    always #8 clk_i = ~clk_i;

    typedef struct {
        int         stamp;
        logic [7:0] data;
        bit         last;
        bit         err;
    } strobe_t;

    strobe_t    expQ[$];
    strobe_t    logQ[$];
    strobe_t    cmpEntry;
    bit [3:0]   cmdAt    [HIST];
    bit         activeAt [HIST];
    int         cyc = 0;
    int         nCompared = 0;
    int         nMismatch = 0;

    // Packet-level model state
    bit         inPkt = 0;
    bit         haveHeld = 0;
    logic [7:0] held = 8'h00;
    int         pktBytes = 0;
    bit         pktErr = 0;
    logic [7:0] lastCmd = 8'h00;
    int         expLastCnt = 0;
    int         expErrCnt = 0;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic beginCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic endCycle(input bit d, input bit n, input logic [7:0] data);
        rst_i       = 1'b0;
        ulpi_dir_i  = d;
        ulpi_nxt_i  = n;
        ulpi_data_i = data;
        if (cyc < HIST) begin
            cmdAt[cyc]    = lastCmd[3:0];
            activeAt[cyc] = inPkt;
        end
    endtask

    task automatic pushStrobe(input logic [7:0] data, input bit last, input bit err);
        strobe_t s;
        s.stamp = cyc + 2;
        s.data  = data;
        s.last  = last;
        s.err   = err;
        expQ.push_back(s);
        if (last) expLastCnt++;
        if (last && err) expErrCnt++;
    endtask

    task automatic openPkt();
        inPkt    = 1;
        haveHeld = 0;
        pktBytes = 0;
        pktErr   = 0;
    endtask

    task automatic closePkt();
        if (haveHeld) pushStrobe(held, 1'b1, pktErr);
        inPkt    = 0;
        haveHeld = 0;
    endtask

    task automatic addByte(input logic [7:0] b);
        if (pktBytes < MAX_BYTES) begin
            if (haveHeld) pushStrobe(held, 1'b0, 1'b0);
            held     = b;
            haveHeld = 1;
            pktBytes++;
        end else begin
            pktErr = 1;
        end
    endtask

    task automatic turnaround(input bit nxt, input logic [7:0] data);
        beginCycle();
        if (nxt) openPkt();
        endCycle(1'b1, nxt, data);
    endtask

    task automatic rxCmd(input logic [7:0] cmd);
        logic [1:0] ev;
        beginCycle();
        lastCmd = cmd;
        ev = cmd[5:4];
        if (inPkt) begin
            if (ev == 2'b00 || ev == 2'b10) closePkt();
            else if (ev == 2'b11) pktErr = 1;
        end else begin
            if (ev == 2'b01) openPkt();
            else if (ev == 2'b11) begin
                openPkt();
                pktErr = 1;
            end
        end
        endCycle(1'b1, 1'b0, cmd);
    endtask

    task automatic dataByte(input logic [7:0] b);
        beginCycle();
        if (!inPkt) openPkt();
        addByte(b);
        endCycle(1'b1, 1'b1, b);
    endtask

    task automatic dirLow(input int n);
        logic [7:0] junk;
        for (int i = 0; i < n; i++) begin
            beginCycle();
            if (inPkt) closePkt();
            junk = 8'($urandom);
            endCycle(1'b0, junk[0], junk);
        end
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            beginCycle();
            if (i == 0) begin
                if (cyc >= 1 && cyc - 1 < HIST) begin
                    cmdAt[cyc-1]    = 4'h0;
                    activeAt[cyc-1] = 1'b0;
                end
                while (expQ.size() > 0 && expQ[$].stamp >= cyc + 1) void'(expQ.pop_back());
            end
            inPkt      = 0;
            haveHeld   = 0;
            lastCmd    = 8'h00;
            expLastCnt = 0;
            expErrCnt  = 0;
            endCycle(1'b0, 1'b0, 8'h00);
            rst_i = 1'b1;
        end
    endtask

    function automatic logic [7:0] mkCmd(input logic [1:0] ev);
        logic [7:0] r;
        r = 8'($urandom);
        return {r[7:6], ev, r[3:0]};
    endfunction

    task automatic checkLog(input int idx, input logic [7:0] data, input bit last, input bit err);
        if (logQ.size() > idx) begin
            checkOutput($sformatf("log%0d.data", idx), logQ[idx].data, data);
            checkOutput($sformatf("log%0d.last", idx), logQ[idx].last, last);
            checkOutput($sformatf("log%0d.err", idx),  logQ[idx].err,  err);
        end else begin
            checkOutput($sformatf("log%0d.present", idx), logQ.size(), idx + 1);
        end
    endtask

    task automatic applyStimulus(input int nPkts);
        int nb;
        for (int p = 0; p < nPkts; p++) begin
            dirLow($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                turnaround(1'b1, 8'($urandom));
            end else begin
                turnaround(1'b0, 8'($urandom));
                if ($urandom_range(0, 2) == 0) rxCmd(mkCmd(2'b00));
                if ($urandom_range(0, 1) == 1) rxCmd(mkCmd(2'b01));
            end
            nb = $urandom_range(0, 20);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 5) == 0)
                    rxCmd(mkCmd((inPkt && $urandom_range(0, 7) == 0) ? 2'b11 : 2'b01));
                dataByte(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                rxCmd(mkCmd(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00));
                repeat ($urandom_range(0, 2)) rxCmd(mkCmd(2'b00));
            end
            dirLow(1);
        end
    endtask

    // Compare the DUT against the model on every falling edge once reset has settled
    always @(negedge clk_i) begin
        if (cyc >= 4) begin
            checkOutput("ulpiDataNoop", ulpi_data_o, 0);
            checkOutput("stpLow", ulpi_stp_o, 0);
            if (cyc - 2 < HIST) begin
                checkOutput("linestate", linestate_o, cmdAt[cyc-2][1:0]);
                checkOutput("vbus", vbus_o, cmdAt[cyc-2][3:2]);
                checkOutput("rxActive", rx_active_o, activeAt[cyc-2]);
            end
            while (expQ.size() > 0 && expQ[0].stamp < cyc) begin
                checkOutput("missingStrobe", cyc, expQ[0].stamp);
                void'(expQ.pop_front());
            end
            if (rx_valid_o) begin
                cmpEntry.stamp = cyc;
                cmpEntry.data  = rx_data_o;
                cmpEntry.last  = rx_last_o;
                cmpEntry.err   = rx_err_o;
                logQ.push_back(cmpEntry);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedStrobe", 1, 0);
                end else begin
                    cmpEntry = expQ.pop_front();
                    checkOutput("strobeCycle", cyc, cmpEntry.stamp);
                    checkOutput("strobeData", rx_data_o, cmpEntry.data);
                    checkOutput("strobeLast", rx_last_o, cmpEntry.last);
                    checkOutput("strobeErr", rx_err_o, cmpEntry.err);
                end
            end
        end
    end

    // Bound the total run time
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic
    initial begin
        int nLast;
        int nErr;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        dirLow(3);
        checkOutput("resetRxActive", rx_active_o, 0);
        checkOutput("resetLinestate", linestate_o, 0);
        checkOutput("resetRxValid", rx_valid_o, 0);

        // RxActive-started packet closed by an RX CMD
        logQ.delete();
        dirLow(2);
        turnaround(1'b0, 8'h00);
        rxCmd(8'h11);
        dataByte(8'hA5);
        dataByte(8'h3C);
        dataByte(8'h7E);
        rxCmd(8'h01);
        dirLow(4);
        checkOutput("t1Count", logQ.size(), 3);
        checkLog(0, 8'hA5, 1'b0, 1'b0);
        checkLog(1, 8'h3C, 1'b0, 1'b0);
        checkLog(2, 8'h7E, 1'b1, 1'b0);
        checkOutput("t1Linestate", linestate_o, 2'b01);

        // PHY-initiated packet closed by dir dropping
        logQ.delete();
        dirLow(2);
        turnaround(1'b1, 8'h00);
        dataByte(8'hC3);
        dataByte(8'h00);
        dirLow(4);
        checkOutput("t2Count", logQ.size(), 2);
        checkLog(0, 8'hC3, 1'b0, 1'b0);
        checkLog(1, 8'h00, 1'b1, 1'b0);
        checkOutput("t2RxActive", rx_active_o, 0);

        // RxError inside a packet
        logQ.delete();
        dirLow(2);
        turnaround(1'b0, 8'h00);
        rxCmd(8'h11);
        dataByte(8'h69);
        dataByte(8'h12);
        rxCmd(8'h31);
        rxCmd(8'h01);
        dirLow(4);
        checkOutput("t3Count", logQ.size(), 2);
        checkLog(0, 8'h69, 1'b0, 1'b0);
        checkLog(1, 8'h12, 1'b1, 1'b1);

        // Overlength packet
        logQ.delete();
        dirLow(2);
        turnaround(1'b1, 8'h00);
        for (int i = 0; i < 1030; i++) dataByte(8'(i));
        dirLow(4);
        checkOutput("t4Count", logQ.size(), 1027);
        nLast = 0;
        nErr  = 0;
        foreach (logQ[i]) begin
            if (logQ[i].last) nLast++;
            if (logQ[i].err) nErr++;
        end
        checkOutput("t4LastCount", nLast, 1);
        checkOutput("t4ErrCount", nErr, 1);
        checkLog(1026, 8'h02, 1'b1, 1'b1);

        // Reset in the middle of a packet
        logQ.delete();
        dirLow(2);
        turnaround(1'b0, 8'h00);
        rxCmd(8'h11);
        dataByte(8'h11);
        dataByte(8'h22);
        rxCmd(8'h11);
        rxCmd(8'h11);
        doReset(2);
        dirLow(4);
        checkOutput("t5Count", logQ.size(), 1);
        checkLog(0, 8'h11, 1'b0, 1'b0);
        checkOutput("t5RxActive", rx_active_o, 0);
        checkOutput("t5Linestate", linestate_o, 0);

        applyStimulus(40);
        dirLow(6);
        checkOutput("expQueueDrained", expQ.size(), 0);
`ifdef ULPI_RX_STATS_EN
        checkOutput("pktCount", pktCount, expLastCnt);
        checkOutput("errCount", errCount, expErrCnt);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
